// File: rtl/f2sdram_arb_pkg.sv
// Shared types and helpers for the FPGA-to-SDRAM round-robin arbiter.
// Widths here are sized for the largest legal configuration (8 requesters).
package f2sdram_arb_pkg;

  localparam int ARB_ID_W    = 3;
  localparam int ARB_BEATS_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WBURST
  } arb_state_e;

  typedef struct packed {
    logic [ARB_ID_W-1:0]    id;
    logic [ARB_BEATS_W-1:0] beats;
  } rd_tag_t;

  typedef struct packed {
    logic                found;
    logic [ARB_ID_W-1:0] idx;
  } rr_pick_t;

  // Bits above the real requester count are zero, so a mod-8 scan gives the
  // same winner as a mod-N_REQ scan starting at ptr.
  function automatic rr_pick_t rr_pick(input logic [7:0] req, input logic [ARB_ID_W-1:0] ptr);
    rr_pick_t            r;
    logic [ARB_ID_W-1:0] k;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      k = ptr + ARB_ID_W'(i);
      if (req[k]) begin
        r.found = 1'b1;
        r.idx   = k;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/f2sdram_tag_fifo.sv
// Read-tag FIFO: first-word-fall-through head, push accepted while full if the
// head is popped in the same cycle.
module f2sdram_tag_fifo
  import f2sdram_arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  rd_tag_t push_tag,
  input  logic    pop,
  output rd_tag_t head_tag,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  rd_tag_t       mem [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic          do_push;
  logic          do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign head_tag = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_tag;
  end

endmodule

// File: rtl/f2sdram_arbiter.sv
// Round-robin, burst-aware arbiter sharing one HPS f2h_sdram Avalon-MM port.
// Optional statistics counters are built when F2SDRAM_ARB_STATS_EN is defined.
module f2sdram_arbiter
  import f2sdram_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int BURST_W    = 8,
  parameter int MAX_RD_OUT = 8
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset_n,
`ifdef F2SDRAM_ARB_STATS_EN
  input  logic                        stat_clear,
  output logic [N_REQ*32-1:0]         stat_grants,
  output logic [31:0]                 stat_stall,
`endif
  input  logic [N_REQ*ADDR_W-1:0]     m_address,
  input  logic [N_REQ-1:0]            m_read,
  input  logic [N_REQ-1:0]            m_write,
  input  logic [N_REQ*DATA_W-1:0]     m_writedata,
  input  logic [N_REQ*DATA_W/8-1:0]   m_byteenable,
  input  logic [N_REQ*BURST_W-1:0]    m_burstcount,
  output logic [N_REQ-1:0]            m_waitrequest,
  output logic [DATA_W-1:0]           m_readdata,
  output logic [N_REQ-1:0]            m_readdatavalid,
  output logic [ADDR_W-1:0]           avm_address,
  output logic                        avm_read,
  output logic                        avm_write,
  output logic [DATA_W-1:0]           avm_writedata,
  output logic [DATA_W/8-1:0]         avm_byteenable,
  output logic [BURST_W-1:0]          avm_burstcount,
  input  logic                        avm_waitrequest,
  input  logic [DATA_W-1:0]           avm_readdata,
  input  logic                        avm_readdatavalid
);

  localparam int GW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0]  addr_a  [N_REQ];
  logic [DATA_W-1:0]  wdata_a [N_REQ];
  logic [BE_W-1:0]    be_a    [N_REQ];
  logic [BURST_W-1:0] burst_a [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign addr_a[i]  = m_address[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = m_writedata[i*DATA_W +: DATA_W];
    assign be_a[i]    = m_byteenable[i*BE_W +: BE_W];
    assign burst_a[i] = m_burstcount[i*BURST_W +: BURST_W];
  end

  arb_state_e         state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0] wbeat_q, wbeat_d;
  logic [BURST_W-1:0] rd_beat_q;

  logic [N_REQ-1:0]   eligible;
  logic [7:0]         req8;
  rr_pick_t           pick;
  logic               cur_rd, cur_wr, in_cmd;
  logic               rd_acc, wr_acc, done;

  rd_tag_t            push_tag, head_tag;
  logic               tag_push, tag_pop, tag_full, tag_empty;
  logic [GW-1:0]      head_id;
  logic [BURST_W-1:0] head_beats;
  logic               rd_valid, rd_last;
  logic               unused_tag_bits;

  // A read asks for a tag slot, so it sits out while the tag FIFO is full.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = m_read[i] ? ~tag_full : m_write[i];
    end
    req8              = '0;
    req8[N_REQ-1:0]   = eligible;
    pick              = rr_pick(req8, ARB_ID_W'(rr_ptr_q));
  end

  assign cur_rd = m_read[grant_q];
  assign cur_wr = m_write[grant_q] & ~cur_rd;
  assign in_cmd = (state_q != IDLE);

  assign avm_address    = addr_a[grant_q];
  assign avm_writedata  = wdata_a[grant_q];
  assign avm_byteenable = be_a[grant_q];
  assign avm_burstcount = burst_a[grant_q];
  assign avm_read       = (state_q == CMD) & cur_rd;
  assign avm_write      = ((state_q == CMD) & cur_wr) | ((state_q == WBURST) & m_write[grant_q]);

  assign rd_acc = avm_read & ~avm_waitrequest;
  assign wr_acc = avm_write & ~avm_waitrequest;

  always_comb begin
    m_waitrequest = '1;
    if (in_cmd) m_waitrequest[grant_q] = avm_waitrequest;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    wbeat_d  = wbeat_q;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick.found) begin
          grant_d = GW'(pick.idx);
          state_d = CMD;
        end
      end
      CMD: begin
        if (rd_acc) begin
          done = 1'b1;
        end else if (wr_acc) begin
          if (avm_burstcount <= BURST_W'(1)) begin
            done = 1'b1;
          end else begin
            wbeat_d = avm_burstcount - BURST_W'(1);
            state_d = WBURST;
          end
        end else if (!cur_rd && !cur_wr) begin
          // Master withdrew its request; release rather than lock the port.
          done = 1'b1;
        end
      end
      WBURST: begin
        if (wr_acc) begin
          if (wbeat_q == BURST_W'(1)) done = 1'b1;
          else                        wbeat_d = wbeat_q - BURST_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      state_d  = IDLE;
      wbeat_d  = '0;
      rr_ptr_d = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + GW'(1);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      wbeat_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      wbeat_q  <= wbeat_d;
    end
  end

  assign tag_push       = rd_acc;
  assign push_tag.id    = ARB_ID_W'(grant_q);
  assign push_tag.beats = ARB_BEATS_W'(avm_burstcount);

  f2sdram_tag_fifo #(
    .DEPTH (MAX_RD_OUT)
  ) u_tag_fifo (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .push     (tag_push),
    .push_tag (push_tag),
    .pop      (tag_pop),
    .head_tag (head_tag),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  // Read return: data is broadcast, valid is steered by the oldest tag.
  assign head_id         = head_tag.id[GW-1:0];
  assign head_beats      = head_tag.beats[BURST_W-1:0];
  assign unused_tag_bits = ^{head_tag.id, head_tag.beats};
  assign rd_valid        = avm_readdatavalid & ~tag_empty;
  assign rd_last         = (rd_beat_q == head_beats - BURST_W'(1)) || (head_beats == '0);
  assign tag_pop         = rd_valid & rd_last;
  assign m_readdata      = avm_readdata;
  assign m_readdatavalid = rd_valid ? (N_REQ'(1) << head_id) : '0;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)  rd_beat_q <= '0;
    else if (rd_valid)   rd_beat_q <= rd_last ? '0 : rd_beat_q + BURST_W'(1);
  end

`ifdef F2SDRAM_ARB_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic [31:0] grant_cnt_q [N_REQ];
  logic [31:0] stall_cnt_q;
  logic        cmd_acc;

  assign cmd_acc = rd_acc | (wr_acc & (state_q == CMD));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < N_REQ; i++) grant_cnt_q[i] <= '0;
      stall_cnt_q <= '0;
    end else if (stat_clear) begin
      for (int i = 0; i < N_REQ; i++) grant_cnt_q[i] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (cmd_acc && (grant_q == GW'(i))) grant_cnt_q[i] <= sat_inc(grant_cnt_q[i]);
      end
      if (in_cmd && avm_waitrequest) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_stat
    assign stat_grants[i*32 +: 32] = grant_cnt_q[i];
  end
  assign stat_stall = stall_cnt_q;
`endif

endmodule

// File: tb/tb_f2sdram_arbiter.sv
// Randomized bench for f2sdram_arbiter: fabric master models, an SDRAM port
// model and a transaction-level round-robin / read-routing reference.
module tb_f2sdram_arbiter;

  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int BW   = 8;
  localparam int MAXO = 8;

  logic              clk;
  logic              reset_reset_n;
  logic [N*AW-1:0]   m_address;
  logic [N-1:0]      m_read, m_write;
  logic [N*DW-1:0]   m_writedata;
  logic [N*DW/8-1:0] m_byteenable;
  logic [N*BW-1:0]   m_burstcount;
  logic [N-1:0]      m_waitrequest;
  logic [DW-1:0]     m_readdata;
  logic [N-1:0]      m_readdatavalid;
  logic [AW-1:0]     avm_address;
  logic              avm_read, avm_write;
  logic [DW-1:0]     avm_writedata;
  logic [DW/8-1:0]   avm_byteenable;
  logic [BW-1:0]     avm_burstcount;
  logic              avm_waitrequest;
  logic [DW-1:0]     avm_readdata;
  logic              avm_readdatavalid;

  f2sdram_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .MAX_RD_OUT(MAXO)
  ) dut (
    .clk_clk           (clk),
    .reset_reset_n     (reset_reset_n),
    .m_address         (m_address),
    .m_read            (m_read),
    .m_write           (m_write),
    .m_writedata       (m_writedata),
    .m_byteenable      (m_byteenable),
    .m_burstcount      (m_burstcount),
    .m_waitrequest     (m_waitrequest),
    .m_readdata        (m_readdata),
    .m_readdatavalid   (m_readdatavalid),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_burstcount    (avm_burstcount),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  // Master models: kind 0 idle, 1 read pending, 2 write burst in progress.
  int          kind  [N];
  int          bc    [N];
  int          wbeat [N];
  int          seq   [N];
  logic [31:0] addr  [N];
  logic [N-1:0] macc;

  // Port-level reference state.
  logic        in_cmd, idle_prev, cur_rd, sacc, srdv;
  logic [N-1:0] elig_prev;
  int          cur_g, cur_bc, wcnt, last_g, out_cnt, rbeat;
  logic [31:0] cur_addr;
  logic [31:0] ret_addr [$];
  int          ret_bc   [$];
  logic [66:0] exp_q    [$];

  int p_req, p_wr, p_wait, p_rv, p_gap;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] be_of(input int i);
    return {4'(i + 1), 4'hF};
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      m_address[i*AW +: AW]      = addr[i];
      m_read[i]                  = (kind[i] == 1);
      m_write[i]                 = (kind[i] == 2) && (wbeat[i] == 0 || $urandom_range(99) >= p_gap);
      m_writedata[i*DW +: DW]    = {addr[i], 32'(wbeat[i])};
      m_byteenable[i*8 +: 8]     = be_of(i);
      m_burstcount[i*BW +: BW]   = BW'(bc[i]);
    end
    avm_waitrequest = ($urandom_range(99) < p_wait);
    if (ret_addr.size() != 0 && $urandom_range(99) < p_rv) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = {ret_addr[0], 32'(rbeat)};
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = {$urandom, $urandom};
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      kind[i] = 0; bc[i] = 1; wbeat[i] = 0; addr[i] = '0;
    end
    macc = '0; sacc = 0; srdv = 0;
    in_cmd = 0; idle_prev = 1; elig_prev = '0; cur_rd = 0;
    cur_g = 0; cur_bc = 1; wcnt = 0; last_g = N - 1; out_cnt = 0; rbeat = 0;
    cur_addr = '0;
    ret_addr.delete(); ret_bc.delete(); exp_q.delete();
    p_req = 0; p_wr = 0; p_wait = 0; p_rv = 0; p_gap = 0;
    drive();
    avm_readdatavalid = 1'b0;
  endtask

  task automatic new_req(input int i, input int k, input int b);
    kind[i]  = k;
    bc[i]    = b;
    wbeat[i] = 0;
    addr[i]  = {4'(i), 12'(seq[i]), 16'h0};
    seq[i]++;
  endtask

  // Observe the cycle just before the active edge and compare with the model.
  task automatic sample();
    logic [N-1:0] exp_wr;
    logic [66:0]  h;
    int           eg;
    if (!in_cmd) begin
      if (idle_prev) begin
        check("cmd_present", 64'(avm_read | avm_write), 64'(|elig_prev));
        if ((avm_read | avm_write) && (|elig_prev)) begin
          eg = -1;
          for (int k = 1; k <= N; k++) begin
            if (eg < 0 && elig_prev[(last_g + k) % N]) eg = (last_g + k) % N;
          end
          check("grant", 64'(avm_address[31:28]), 64'(eg));
          check("addr", 64'(avm_address), 64'(addr[eg]));
          check("op_read", 64'(avm_read), 64'(kind[eg] == 1));
          check("burstcount", 64'(avm_burstcount), 64'(bc[eg]));
          in_cmd = 1; cur_g = eg; cur_addr = addr[eg];
          cur_rd = (kind[eg] == 1); cur_bc = bc[eg]; wcnt = 0;
        end
      end else begin
        check("bubble", 64'(avm_read | avm_write), 64'(0));
      end
    end
    if (in_cmd) begin
      exp_wr = '1;
      exp_wr[cur_g] = avm_waitrequest;
      check("waitreq", 64'(m_waitrequest), 64'(exp_wr));
      check("addr_hold", 64'(avm_address), 64'(cur_addr));
      check("rd_drive", 64'(avm_read), 64'(cur_rd));
      check("wr_drive", 64'(avm_write), 64'(!cur_rd && m_write[cur_g]));
      if (avm_write) begin
        check("wdata", avm_writedata, {cur_addr, 32'(wcnt)});
        check("byteen", 64'(avm_byteenable), 64'(be_of(cur_g)));
      end
    end else begin
      check("idle_wait", 64'(m_waitrequest), 64'({N{1'b1}}));
    end
    if (avm_readdatavalid) begin
      check("rdv_owner", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        h = exp_q.pop_front();
        check("rdv_route", 64'(m_readdatavalid), 64'(4'b0001 << h[66:64]));
        check("rdata", m_readdata, h[63:0]);
      end
    end else begin
      check("rdv_idle", 64'(m_readdatavalid), 64'(0));
    end
    idle_prev = !in_cmd;
    for (int j = 0; j < N; j++) begin
      elig_prev[j] = m_read[j] ? (out_cnt < MAXO) : m_write[j];
    end
    for (int j = 0; j < N; j++) macc[j] = (m_read[j] | m_write[j]) & ~m_waitrequest[j];
    sacc = (avm_read | avm_write) & ~avm_waitrequest;
    srdv = avm_readdatavalid;
  endtask

  task automatic update();
    for (int i = 0; i < N; i++) begin
      if (macc[i] && kind[i] == 1) begin
        for (int b = 0; b < bc[i]; b++) exp_q.push_back({3'(i), addr[i], 32'(b)});
        kind[i] = 0;
      end else if (macc[i] && kind[i] == 2) begin
        wbeat[i]++;
        if (wbeat[i] == bc[i]) kind[i] = 0;
      end
    end
    if (sacc && in_cmd) begin
      if (cur_rd) begin
        ret_addr.push_back(cur_addr);
        ret_bc.push_back(cur_bc);
        out_cnt++;
        in_cmd = 0; last_g = cur_g;
      end else begin
        wcnt++;
        if (wcnt == cur_bc) begin
          in_cmd = 0; last_g = cur_g;
        end
      end
    end
    if (srdv && ret_addr.size() != 0) begin
      rbeat++;
      if (rbeat == ret_bc[0]) begin
        void'(ret_addr.pop_front());
        void'(ret_bc.pop_front());
        rbeat = 0;
        out_cnt--;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (kind[i] == 0 && $urandom_range(99) < p_req) begin
        if ($urandom_range(99) < p_wr) new_req(i, 2, $urandom_range(8, 1));
        else                           new_req(i, 1, $urandom_range(4, 1));
      end
    end
    drive();
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    update();
  endtask

  task automatic run_phase(input int n, input int preq, input int pwr, input int pwait,
                           input int prv, input int pgap);
    p_req = preq; p_wr = pwr; p_wait = pwait; p_rv = prv; p_gap = pgap;
    for (int c = 0; c < n; c++) cycle();
  endtask

  task automatic drain();
    run_phase(400, 0, 0, 5, 100, 0);
    check("drain_reads", 64'(exp_q.size()), 64'(0));
    check("drain_cmd", 64'(in_cmd), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < N; i++) seq[i] = 0;
    reset_reset_n = 1'b0;
    model_reset();
    avm_readdatavalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_avm_read", 64'(avm_read), 64'(0));
    check("rst_avm_write", 64'(avm_write), 64'(0));
    check("rst_waitreq", 64'(m_waitrequest), 64'({N{1'b1}}));
    check("rst_rdvalid", 64'(m_readdatavalid), 64'(0));
    avm_readdatavalid = 1'b0;
    @(posedge clk);
    #1;
    reset_reset_n = 1'b1;

    run_phase(400, 60, 30, 20, 70, 25);
    run_phase(300, 90, 10, 10, 0, 20);
    run_phase(300, 50, 70, 60, 50, 40);
    run_phase(300, 80, 50, 0, 90, 0);
    drain();

    // Write burst of 8 from requester 1, interrupted by reset after beat 3.
    p_req = 0; p_wr = 0; p_wait = 20; p_rv = 100; p_gap = 20;
    new_req(1, 2, 8);
    drive();
    for (int c = 0; c < 300 && wbeat[1] < 3; c++) cycle();
    check("rst_reach_beat3", 64'(wbeat[1]), 64'(3));
    reset_reset_n = 1'b0;
    #1;
    check("midrst_avm_write", 64'(avm_write), 64'(0));
    check("midrst_waitreq", 64'(m_waitrequest), 64'({N{1'b1}}));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_reset_n = 1'b1;

    run_phase(400, 70, 40, 30, 60, 25);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
